// File: rtl/neg_run_monitor.sv
// Tracks runs of negative samples, a saturating negative count and the minimum sample.
// The alarm stalls the input once a run reaches RUN_THRESH and is released by ALARM_ACK.
module neg_run_monitor #(
   parameter int WIDTH      = 8,
   parameter int RUN_THRESH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CLR,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] SAMPLE,
   input  logic             LTZ,
   input  logic             ALARM_ACK,
   output logic             ALARM,
   output logic [CNT_W-1:0] RUN_LEN,
   output logic [CNT_W-1:0] NEG_COUNT,
   output logic [WIDTH-1:0] MIN_VAL,
   output logic             OUT_VALID
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_THRESH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_len_q, run_len_d;
   logic [CNT_W-1:0] neg_count_q, neg_count_d;
   logic [WIDTH-1:0] min_val_q, min_val_d;
   logic             out_valid_q, out_valid_d;
   logic             alarm_q, alarm_d;
   logic             accept;
   logic [CNT_W-1:0] run_len_inc;

   assign IN_READY = (state_q != ST_ALARM);
   assign accept   = IN_VALID && IN_READY;

   assign run_len_inc = (run_len_q == CNT_MAX) ? CNT_MAX : run_len_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      run_len_d   = run_len_q;
      neg_count_d = neg_count_q;
      min_val_d   = min_val_q;
      out_valid_d = 1'b0;

      if (CLR) begin
         state_d     = ST_IDLE;
         run_len_d   = '0;
         neg_count_d = '0;
         min_val_d   = '0;
      end else if (state_q == ST_ALARM) begin
         if (ALARM_ACK) begin
            state_d   = ST_IDLE;
            run_len_d = '0;
         end
      end else if (accept) begin
         out_valid_d = 1'b1;
         if (LTZ) begin
            neg_count_d = (neg_count_q == CNT_MAX) ? CNT_MAX : neg_count_q + 1'b1;
            run_len_d   = run_len_inc;
            state_d     = (run_len_inc == THRESH) ? ST_ALARM : ST_RUN;
         end else begin
            run_len_d = '0;
            state_d   = ST_IDLE;
         end
         // MIN_VAL starts at 0, so only negative samples can ever lower it.
         if ($signed(SAMPLE) < $signed(min_val_q)) begin
            min_val_d = SAMPLE;
         end
      end
   end

   assign alarm_d = (state_d == ST_ALARM);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         run_len_q   <= '0;
         neg_count_q <= '0;
         min_val_q   <= '0;
         out_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_len_q   <= run_len_d;
         neg_count_q <= neg_count_d;
         min_val_q   <= min_val_d;
         out_valid_q <= out_valid_d;
         alarm_q     <= alarm_d;
      end
   end

   assign ALARM     = alarm_q;
   assign RUN_LEN   = run_len_q;
   assign NEG_COUNT = neg_count_q;
   assign MIN_VAL   = min_val_q;
   assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_neg_run_monitor.sv
// Bench for neg_run_monitor: directed scenarios on three parameterisations plus a
// randomized run of the default instance against an integer-level reference model.
module tb_neg_run_monitor;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;

   // default instance: WIDTH=8, RUN_THRESH=4, CNT_W=8
   logic       clr = 1'b0, valid = 1'b0, ltz = 1'b0, ack = 1'b0;
   logic [7:0] sample = '0;
   logic       in_ready, alarm, out_valid;
   logic [7:0] run_len, neg_count, min_val;

   // saturation instance: CNT_W=3
   logic       s_valid = 1'b0, s_ltz = 1'b0;
   logic [7:0] s_sample = '0;
   logic       s_in_ready, s_alarm, s_out_valid;
   logic [2:0] s_run_len, s_neg_count;
   logic [7:0] s_min_val;

   // threshold-of-one instance
   logic       t_valid = 1'b0, t_ltz = 1'b0, t_ack = 1'b0;
   logic [7:0] t_sample = '0;
   logic       t_in_ready, t_alarm, t_out_valid;
   logic [7:0] t_run_len, t_neg_count, t_min_val;

   int checks = 0;
   int failures = 0;

   // reference model state (plain integers)
   int m_run, m_count, m_min;
   bit m_alarm, m_ov;
   localparam int M_THRESH = 4;
   localparam int M_CMAX   = 255;

   always #5 CLK = ~CLK;

   neg_run_monitor #(.WIDTH(8), .RUN_THRESH(4), .CNT_W(8)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CLR(clr), .IN_VALID(valid), .IN_READY(in_ready),
      .SAMPLE(sample), .LTZ(ltz), .ALARM_ACK(ack), .ALARM(alarm), .RUN_LEN(run_len),
      .NEG_COUNT(neg_count), .MIN_VAL(min_val), .OUT_VALID(out_valid)
   );

   neg_run_monitor #(.WIDTH(8), .RUN_THRESH(4), .CNT_W(3)) dut_sat (
      .CLK(CLK), .RESET_N(RESET_N), .CLR(1'b0), .IN_VALID(s_valid), .IN_READY(s_in_ready),
      .SAMPLE(s_sample), .LTZ(s_ltz), .ALARM_ACK(1'b0), .ALARM(s_alarm), .RUN_LEN(s_run_len),
      .NEG_COUNT(s_neg_count), .MIN_VAL(s_min_val), .OUT_VALID(s_out_valid)
   );

   neg_run_monitor #(.WIDTH(8), .RUN_THRESH(1), .CNT_W(8)) dut_t1 (
      .CLK(CLK), .RESET_N(RESET_N), .CLR(1'b0), .IN_VALID(t_valid), .IN_READY(t_in_ready),
      .SAMPLE(t_sample), .LTZ(t_ltz), .ALARM_ACK(t_ack), .ALARM(t_alarm), .RUN_LEN(t_run_len),
      .NEG_COUNT(t_neg_count), .MIN_VAL(t_min_val), .OUT_VALID(t_out_valid)
   );

   task automatic model_update();
      m_ov = 1'b0;
      if (!RESET_N || clr) begin
         m_run = 0; m_count = 0; m_min = 0; m_alarm = 1'b0;
      end else if (m_alarm) begin
         if (ack) begin
            m_run = 0; m_alarm = 1'b0;
         end
      end else if (valid) begin
         m_ov = 1'b1;
         if (ltz) begin
            m_count = (m_count + 1 > M_CMAX) ? M_CMAX : m_count + 1;
            m_run = m_run + 1;
            if (m_run == M_THRESH) m_alarm = 1'b1;
         end else begin
            m_run = 0;
         end
         if ($signed(sample) < m_min) m_min = $signed(sample);
      end
   endtask

   // advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      model_update();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_main(input bit v, input int s);
      valid = v;
      sample = 8'(s);
      ltz = (s < 0);
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      set_main(1, -3);
      s_valid = 1'b1; s_sample = 8'hFD; s_ltz = 1'b1;
      t_valid = 1'b1; t_sample = 8'hFD; t_ltz = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || s_out_valid !== 1'b0 || t_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid cyc=%0d got=%b%b%b want=000", i, out_valid, s_out_valid, t_out_valid);
         end
      end
      RESET_N = 1'b1;
      set_main(0, 0);
      s_valid = 1'b0; t_valid = 1'b0;
      #1;
      checks++;
      if ({alarm, run_len, neg_count, min_val, out_valid, in_ready} !== {1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got alarm=%b run=%0d cnt=%0d min=%0d ov=%b rdy=%b want 0,0,0,0,0,1",
                  alarm, run_len, neg_count, $signed(min_val), out_valid, in_ready);
      end
      checks++;
      if ({s_neg_count, t_alarm, t_run_len, t_in_ready} !== {3'd0, 1'b0, 8'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state_aux got scnt=%0d talarm=%b trun=%0d trdy=%b", s_neg_count, t_alarm, t_run_len, t_in_ready);
      end
   endtask

   task automatic test_alarm_sequence();
      int samples [7] = '{-5, -1, 7, -2, -2, -2, -2};
      int exp_run [7] = '{1, 2, 0, 1, 2, 3, 4};
      for (int i = 0; i < 7; i++) begin
         set_main(1, samples[i]);
         step();
         $display("txn alarm_seq sample=%0d run=%0d cnt=%0d alarm=%b", samples[i], run_len, neg_count, alarm);
         checks++;
         if (run_len !== 8'(exp_run[i]) || out_valid !== 1'b1 || alarm !== (i == 6)) begin
            failures++;
            $display("FAIL alarm_seq_run idx=%0d got run=%0d ov=%b alarm=%b want run=%0d ov=1 alarm=%b",
                     i, run_len, out_valid, alarm, exp_run[i], (i == 6));
         end
      end
      checks++;
      if (in_ready !== 1'b0 || neg_count !== 8'd6 || min_val !== 8'hFB) begin
         failures++;
         $display("FAIL alarm_seq_end got rdy=%b cnt=%0d min=%0d want rdy=0 cnt=6 min=-5", in_ready, neg_count, $signed(min_val));
      end
   endtask

   task automatic test_stall_ack();
      set_main(1, -9);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || alarm !== 1'b1 || in_ready !== 1'b0 || neg_count !== 8'd6 || run_len !== 8'd4) begin
            failures++;
            $display("FAIL stall cyc=%0d got ov=%b alarm=%b rdy=%b cnt=%0d run=%0d want 0,1,0,6,4",
                     i, out_valid, alarm, in_ready, neg_count, run_len);
         end
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if (alarm !== 1'b0 || in_ready !== 1'b1 || run_len !== 8'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ack_release got alarm=%b rdy=%b run=%0d ov=%b want 0,1,0,0", alarm, in_ready, run_len, out_valid);
      end
      step();
      $display("txn stall_ack sample=-9 run=%0d min=%0d", run_len, $signed(min_val));
      checks++;
      if (run_len !== 8'd1 || min_val !== 8'hF7 || neg_count !== 8'd7 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL ack_next_accept got run=%0d min=%0d cnt=%0d ov=%b want 1,-9,7,1",
                  run_len, $signed(min_val), neg_count, out_valid);
      end
   endtask

   task automatic test_clear();
      step();  // second -9: RUN_LEN=2
      checks++;
      if (run_len !== 8'd2) begin
         failures++;
         $display("FAIL clear_setup got run=%0d want 2", run_len);
      end
      set_main(1, -1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if ({run_len, neg_count, min_val, out_valid, alarm, in_ready} !== {8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL clear_collision got run=%0d cnt=%0d min=%0d ov=%b alarm=%b rdy=%b want 0,0,0,0,0,1",
                  run_len, neg_count, $signed(min_val), out_valid, alarm, in_ready);
      end
      step();
      checks++;
      if (run_len !== 8'd1 || neg_count !== 8'd1 || min_val !== 8'hFF) begin
         failures++;
         $display("FAIL clear_restart got run=%0d cnt=%0d min=%0d want 1,1,-1", run_len, neg_count, $signed(min_val));
      end
      set_main(0, 0);
   endtask

   task automatic test_saturation();
      int negs = 0;
      for (int i = 0; i < 19; i++) begin
         s_valid = 1'b1;
         if (i == 0) s_sample = 8'h80;
         else if (i % 2 == 1) s_sample = 8'h00;
         else s_sample = 8'($urandom_range(1, 127)) ^ 8'hFF;  // -2..-128 range, never positive
         s_ltz = s_sample[7];
         if (s_ltz) negs++;
         step();
         checks++;
         if (s_neg_count !== 3'((negs > 7) ? 7 : negs) || s_alarm !== 1'b0 || s_min_val !== 8'h80) begin
            failures++;
            $display("FAIL saturation idx=%0d got cnt=%0d alarm=%b min=%0d want cnt=%0d alarm=0 min=-128",
                     i, s_neg_count, s_alarm, $signed(s_min_val), (negs > 7) ? 7 : negs);
         end
      end
      s_valid = 1'b0;
      step();
      checks++;
      if (s_neg_count !== 3'd7 || s_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL saturation_hold got cnt=%0d ov=%b want 7,0", s_neg_count, s_out_valid);
      end
   endtask

   task automatic test_thresh_one();
      t_valid = 1'b1; t_sample = 8'hFF; t_ltz = 1'b1; t_ack = 1'b1;
      step();
      t_valid = 1'b0; t_ack = 1'b0;
      checks++;
      if (t_alarm !== 1'b1 || t_run_len !== 8'd1 || t_in_ready !== 1'b0 || t_out_valid !== 1'b1) begin
         failures++;
         $display("FAIL thresh_one got alarm=%b run=%0d rdy=%b ov=%b want 1,1,0,1", t_alarm, t_run_len, t_in_ready, t_out_valid);
      end
      t_ack = 1'b1;
      step();
      t_ack = 1'b0;
      checks++;
      if (t_alarm !== 1'b0 || t_run_len !== 8'd0 || t_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL thresh_one_ack got alarm=%b run=%0d rdy=%b want 0,0,1", t_alarm, t_run_len, t_in_ready);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_min;
      for (int i = 0; i < 400; i++) begin
         int s;
         s = ($urandom_range(0, 9) < 6) ? -int'($urandom_range(1, 128)) : int'($urandom_range(0, 127));
         set_main($urandom_range(0, 3) != 0, s);
         ack = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 60) == 0);
         step();
         if (out_valid) $display("txn random i=%0d run=%0d cnt=%0d min=%0d alarm=%b", i, run_len, neg_count, $signed(min_val), alarm);
         exp_min = 8'(m_min);
         checks++;
         if (run_len !== 8'(m_run) || neg_count !== 8'(m_count) || min_val !== exp_min ||
             alarm !== m_alarm || out_valid !== m_ov || in_ready !== !m_alarm) begin
            failures++;
            $display("FAIL random i=%0d got run=%0d cnt=%0d min=%0d alarm=%b ov=%b rdy=%b want %0d,%0d,%0d,%b,%b,%b",
                     i, run_len, neg_count, $signed(min_val), alarm, out_valid, in_ready,
                     m_run, m_count, m_min, m_alarm, m_ov, !m_alarm);
         end
      end
      set_main(0, 0);
      ack = 1'b0;
      clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alarm_sequence();
      test_stall_ack();
      test_clear();
      test_saturation();
      test_thresh_one();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/neg_run_monitor.md
# neg_run_monitor

- Sequential stage directly downstream of the less-than-zero detector.
- Accepts a stream of signed samples together with the detector's sign flag over a valid/ready handshake.
- Tracks the current run of consecutive negative samples, a saturating count of all negatives and the most negative value seen.
- Raises an alarm that stalls the input until acknowledged once a negative run reaches a threshold.

## Interface

- WIDTH, 8, sample width (two's complement), matches the detector input width
- RUN_THRESH, 4, consecutive-negative run length that triggers the alarm (legal range 1 to 2^CNT_W-1)
- CNT_W, 8, width of the run-length and negative-count counters

Ports:

- CLK  input  1  single clock, rising-edge
- RESET_N  input  1  asynchronous, active-low reset
- CLR  input  1  synchronous clear of all state and statistics
- IN_VALID  input  1  sample/flag pair present
- IN_READY  output  1  block can accept a sample this cycle
- SAMPLE  input  WIDTH  signed sample (the detector's A)
- LTZ  input  1  detector output F (1 = SAMPLE < 0)
- ALARM_ACK  input  1  acknowledges the alarm and releases the stall
- ALARM  output  1  high while in ALARM state
- RUN_LEN  output  CNT_W  current consecutive-negative run length
- NEG_COUNT  output  CNT_W  total negatives accepted since reset/clear, saturating
- MIN_VAL  output  WIDTH  signed minimum of 0 and all accepted samples
- OUT_VALID  output  1  one-cycle pulse: statistics updated by an accepted sample

## Operation

- Accept happens when IN_VALID && IN_READY at a rising CLK edge.
- IN_READY is combinational from state: 1 in IDLE and RUN, 0 in ALARM.
- Run and count logic use LTZ only. MIN_VAL uses SAMPLE with a signed compare. LTZ is not rechecked against SAMPLE[WIDTH-1]; the bench must drive them consistently.

State machine:

- IDLE: run length is 0.
  - Accept with LTZ=1: RUN_LEN=1, go to RUN; go to ALARM instead if RUN_THRESH==1.
  - Accept with LTZ=0: stay in IDLE.
- RUN: 1 ≤ RUN_LEN < RUN_THRESH.
  - Accept with LTZ=1: RUN_LEN+1; go to ALARM when the new value equals RUN_THRESH.
  - Accept with LTZ=0: RUN_LEN=0, go to IDLE.
- ALARM: no accepts.
  - ALARM_ACK=1: RUN_LEN=0, go to IDLE next edge.
  - ALARM_ACK in IDLE or RUN is ignored.

Statistics:

- NEG_COUNT increments on each accept with LTZ=1 and saturates at 2^CNT_W-1 (no wrap).
- RUN_LEN also saturates at 2^CNT_W-1; this is unreachable given the legal RUN_THRESH range.
- MIN_VAL becomes SAMPLE on accept if SAMPLE < MIN_VAL (signed). The most negative value (-2^(WIDTH-1)) is held permanently until reset or clear.

Clear and priority:

- CLR=1 forces IDLE and zeroes RUN_LEN, NEG_COUNT and MIN_VAL. A sample presented in the same cycle is discarded and OUT_VALID stays 0.
- Priority: RESET_N > CLR > ALARM_ACK > sample accept.

## Timing

- Reset (RESET_N low, asynchronous assert): ALARM=0, RUN_LEN=0, NEG_COUNT=0, MIN_VAL=0, OUT_VALID=0, state IDLE, so IN_READY=1.
- Reset deassertion is expected synchronous to CLK, provided externally.
- Latency is 1 cycle. All outputs except IN_READY are registered. For a sample accepted at edge N, RUN_LEN, NEG_COUNT, MIN_VAL, ALARM and OUT_VALID=1 are visible after edge N. OUT_VALID returns to 0 after edge N+1 unless another sample is accepted.
- Throughput is one sample per cycle outside ALARM.
- The sample that completes the run is accepted. IN_READY drops in the cycle right after that edge.
- ALARM_ACK is sampled at an edge. ALARM and the stall release after that edge; the earliest next accept is the following edge.
- Holding ALARM_ACK high for several cycles is harmless.
- Reset asserted mid-run or mid-alarm takes effect immediately, with no partial update.

## Test plan

- Reset check: hold RESET_N=0 with IN_VALID=1, SAMPLE=-3, LTZ=1, then release → all outputs 0, IN_READY=1, no OUT_VALID while in reset.
- Alarm sequence, RUN_THRESH=4: stream -5,-1,7,-2,-2,-2,-2 with LTZ matching, one per cycle.
  - RUN_LEN goes 1,2,0,1,2,3,4.
  - ALARM rises after the 7th accept, and IN_READY=0 from then on.
  - NEG_COUNT=6, MIN_VAL=-5.
- Stall and acknowledge: hold IN_VALID=1, SAMPLE=-9 for 3 cycles in ALARM → no accept and no OUT_VALID. Pulse ALARM_ACK → IDLE, RUN_LEN=0, and the next accept of -9 gives RUN_LEN=1, MIN_VAL=-9.
- Saturation and extremes, CNT_W=3: stream -128, then 9 further negatives interleaved with 0 so no alarm fires → NEG_COUNT=7 and held there, MIN_VAL=-128.
- Clear collision: in RUN with RUN_LEN=2, assert CLR together with IN_VALID, SAMPLE=-1 → all statistics 0, state IDLE, OUT_VALID=0.
- Threshold of one, RUN_THRESH=1: a single accept of -1 → ALARM=1 and RUN_LEN=1 after that edge. Asserting ALARM_ACK in the same cycle as a sample in IDLE has no effect on the ack path.
